addf_serial_seq: RTL
====================

Name: addf_serial_seq

Overview:
Bit-serial adder sequencer that time-shares one full-adder cell (gf180mcu_fd_sc_mcu7t5v0__addf_2) to add two WIDTH-bit operands LSB-first, one bit per clock.
- Carry is held in a flop between bits.
- The block sits beside small-area MCU datapaths where a ripple adder is too large.
- Start/busy/done handshake, with results held stable between operations.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32, elaborate-time error outside it.

Ports:
- CLK  input  1  rising-edge clock
- RN  input  1  asynchronous active-low reset
- START  input  1  request; sampled only when the block can accept
- A  input  WIDTH  operand A; captured on the accepting edge
- B  input  WIDTH  operand B; captured on the accepting edge
- CIN  input  1  carry-in; captured on the accepting edge
- BUSY  output  1  high while bits are being processed
- DONE  output  1  single-cycle completion pulse
- SUM  output  WIDTH  result; updated only at completion
- COUT  output  1  final carry-out; updated only at completion

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RN).
- RN low forces, immediately and regardless of CLK:
  - state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0
  - operand shift registers, carry flop and bit counter to 0
- States: IDLE, RUN, FIN.
- IDLE:
  - START=1 at an edge accepts the request: a_sr<=A, b_sr<=B, c<=CIN, cnt<=0, go to RUN.
  - START=0 stays in IDLE.
- RUN, each edge:
  - The addf cell sees (a_sr[0], b_sr[0], c).
  - s_sr shifts right with cell S inserted at MSB; a_sr and b_sr shift right with zero fill.
  - c<=cell CO; cnt<=cnt+1.
  - When cnt==WIDTH-1 on that edge: SUM<=final s_sr value (including this bit), COUT<=CO, go to FIN.
- FIN (one cycle):
  - DONE=1.
  - START=1 at the next edge is accepted as in IDLE and goes directly to RUN (back-to-back, no gap cycle).
  - START=0 goes to IDLE.
- BUSY=1 exactly in RUN; DONE=1 exactly in FIN. Both are registered decodes of state, so they are glitch-free.
- Latency: with START accepted at edge k, the RUN edges are k+1..k+WIDTH, and SUM/COUT/DONE become valid after edge k+WIDTH. DONE is high for one cycle only.
- Throughput: one add per WIDTH+1 cycles.
- START while BUSY=1 is ignored: no queueing, no effect on the operation in flight. A and B changing during RUN have no effect.
- SUM and COUT keep the previous result through IDLE and RUN, and change only on the completing edge.
- Arithmetic: {COUT,SUM} = A + B + CIN, modulo 2^(WIDTH+1), unsigned. cnt width is $clog2(WIDTH+1).
- WIDTH=1: the single RUN cycle completes immediately; DONE follows START acceptance by one edge.
- Reset mid-operation: aborts, with no DONE pulse and SUM/COUT cleared to 0. After RN is released, the first edge behaves as IDLE.
- Power pins: VDD/VSS ports exist only under USE_POWER_PINS and are passed to the adder cell instance.

Decomposition:
- Shared package addf_seq_pkg:
  - state enum {IDLE, RUN, FIN} (2-bit encoding)
  - constants WIDTH_MIN=1, WIDTH_MAX=32
  - function cnt_w(width) returning $clog2(width+1)
- One sub-module: a single instance of the codebase full-adder cell gf180mcu_fd_sc_mcu7t5v0__addf_2 as the bit slice.
- Control (FSM, counter) and shift registers stay in addf_serial_seq.

Test Plan:
- WIDTH=8, A=0x5A, B=0x33, CIN=0, START 1 cycle:
  - BUSY high for 8 cycles, then DONE for 1 cycle
  - SUM=0x8D, COUT=0
- WIDTH=8, A=0xFF, B=0x01, CIN=0 gives SUM=0x00, COUT=1. Then A=0xFF, B=0xFF, CIN=1 gives SUM=0xFF, COUT=1.
- START pulsed again at RUN cycle 3 with A=0x11, B=0x22:
  - ignored; the original result 0x8D/0 completes on schedule
  - only one DONE pulse
- START held high continuously, with operands (0x01,0x01,0) then (0x80,0x80,1):
  - DONE pulses every 9 cycles
  - results 0x02/0 then 0x01/1
  - SUM holds 0x02 during the second RUN
- RN asserted low asynchronously mid-cycle during RUN bit 4:
  - BUSY, DONE, SUM and COUT go to 0 immediately
  - no DONE after release
  - the next START with 0x0F+0x01 gives 0x10/0
- WIDTH=1, A=1, B=1, CIN=1: DONE one cycle after acceptance, SUM=1, COUT=1.

Source files
------------

// File: rtl/addf_seq_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state
// encoding, legal width range and the bit-counter width helper.
package addf_seq_pkg;

  // Sequencer states; two bits cover the three states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Bits needed to count from 0 to width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_2.sv
// Behavioural model of the gf180mcu 7-track full-adder standard cell,
// used as the single time-shared bit slice of the serial adder.
module gf180mcu_fd_sc_mcu7t5v0__addf_2 (
`ifdef USE_POWER_PINS
  inout  wire VDD,
  inout  wire VSS,
`endif
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  assign S  = A ^ B ^ CI;
  assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/addf_serial_seq.sv
// Bit-serial adder sequencer: one full-adder cell adds two WIDTH-bit
// operands LSB-first, one bit per clock, with the carry held in a flop.
// Start/busy/done handshake; SUM/COUT change only on the completing edge.
module addf_serial_seq
  import addf_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int                CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  // Reject out-of-range widths at elaboration.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("addf_serial_seq: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic [WIDTH-1:0] s_nxt;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             co_bit;
  logic             accept;
  logic             last_bit;

  // The one shared bit slice always looks at the operand LSBs and the carry.
  gf180mcu_fd_sc_mcu7t5v0__addf_2 u_addf (
`ifdef USE_POWER_PINS
    .VDD (VDD),
    .VSS (VSS),
`endif
    .A   (a_sr[0]),
    .B   (b_sr[0]),
    .CI  (c),
    .S   (s_bit),
    .CO  (co_bit)
  );

  // A request is taken in IDLE and, back-to-back, in FIN; never while busy.
  assign accept   = START && (state == IDLE || state == FIN);
  assign last_bit = (cnt == CNT_LAST);
  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign s_nxt    = (s_sr >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  // Next-state decode.
  always_comb begin
    // NOTE: every branch starts from a default so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = FIN;
      FIN:     state_nxt = START ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus registered BUSY/DONE decodes, so both are glitch-free.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state <= state_nxt;
      BUSY  <= (state_nxt == RUN);
      DONE  <= (state_nxt == FIN);
    end
  end

  // Operand capture, serial shifting, carry, bit counter and result update.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      // NOTE: the shift registers are reset too, so an aborted add leaves no residue.
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      SUM  <= '0;
      COUT <= 1'b0;
    end else if (accept) begin
      a_sr <= A;
      b_sr <= B;
      c    <= CIN;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= s_nxt;
      c    <= co_bit;
      cnt  <= cnt + CNT_W'(1);
      if (last_bit) begin
        SUM  <= s_nxt;
        COUT <= co_bit;
      end
    end
  end

endmodule
